// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive sequencer and its shift register,
// receive buffer and consumer.
interface uart_rx_ctrl_if;
  logic serial_in;
  logic stop_bit;
  logic data_read;
  logic shift_strobe;
  logic load_buffer;
  logic rx_busy;
  logic data_ready;
  logic framing_error;
  logic overrun_error;

  modport master (
    output serial_in,
    output stop_bit,
    output data_read,
    input  shift_strobe,
    input  load_buffer,
    input  rx_busy,
    input  data_ready,
    input  framing_error,
    input  overrun_error
  );

  modport slave (
    input  serial_in,
    input  stop_bit,
    input  data_read,
    output shift_strobe,
    output load_buffer,
    output rx_busy,
    output data_ready,
    output framing_error,
    output overrun_error
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit qualification, mid-bit shift strobes,
// stop-bit check, buffer load and receive status flags.
module uart_rx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic           clk,
  input  logic           n_rst,
  uart_rx_ctrl_if.slave  bus
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned TW   = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    RECV,
    STOP_CHK,
    LOAD
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [3:0]    bit_cnt, bit_cnt_d;
  logic          prev_rx;
  logic          start_edge;
  logic          strobe;
  logic          data_ready_q, data_ready_d;
  logic          framing_q, framing_d;
  logic          overrun_q, overrun_d;

  assign start_edge = prev_rx & ~bus.serial_in;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      timer        <= '0;
      bit_cnt      <= '0;
      prev_rx      <= 1'b1;
      data_ready_q <= 1'b0;
      framing_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state        <= state_d;
      timer        <= timer_d;
      bit_cnt      <= bit_cnt_d;
      prev_rx      <= bus.serial_in;
      data_ready_q <= data_ready_d;
      framing_q    <= framing_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state;
    timer_d   = '0;
    bit_cnt_d = bit_cnt;
    strobe    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_edge) state_d = START_CHK;
      end
      START_CHK: begin
        timer_d = timer + TW'(1);
        if (timer == T_HALF) state_d = bus.serial_in ? IDLE : RECV;
      end
      RECV: begin
        timer_d = timer + TW'(1);
        if (timer == T_LAST) begin
          strobe    = 1'b1;
          timer_d   = '0;
          bit_cnt_d = bit_cnt + 4'd1;
          if (bit_cnt == 4'd8) state_d = STOP_CHK;
        end
      end
      STOP_CHK: begin
        state_d = bus.stop_bit ? LOAD : IDLE;
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every state entry restarts both counters.
    if (state_d != state) begin
      timer_d   = '0;
      bit_cnt_d = '0;
    end
  end

  always_comb begin
    framing_d    = framing_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;

    if (state == IDLE && start_edge)
      framing_d = 1'b0;
    else if (state == STOP_CHK && !bus.stop_bit)
      framing_d = 1'b1;

    // A load wins over a coincident read, so the fresh byte stays flagged.
    if (state == LOAD)
      data_ready_d = 1'b1;
    else if (bus.data_read)
      data_ready_d = 1'b0;

    if (state == LOAD && data_ready_q && !bus.data_read)
      overrun_d = 1'b1;
    else if (bus.data_read)
      overrun_d = 1'b0;
  end

  assign bus.shift_strobe  = strobe;
  assign bus.load_buffer   = (state == LOAD);
  assign bus.rx_busy       = (state != IDLE);
  assign bus.data_ready    = data_ready_q;
  assign bus.framing_error = framing_q;
  assign bus.overrun_error = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural 9-bit receive shift register.
module tb_uart_rx_ctrl;

  localparam int unsigned CPB = 10;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] sr = '0;
  always @(posedge clk) if (bus.shift_strobe) sr <= {bus.serial_in, sr[8:1]};
  assign bus.stop_bit = sr[8];

  // Event log: strobe/load entries hold the edge that ends the active cycle,
  // rise/fall entries hold the edge after which the change was seen.
  int   strobe_q[$];
  int   load_q[$];
  int   busy_rise, busy_fall, dr_rise, fe_rise, fe_fall, ov_rise;
  logic busy_p = 1'b0, dr_p = 1'b0, fe_p = 1'b0, ov_p = 1'b0;

  always @(negedge clk) begin
    if (bus.shift_strobe) strobe_q.push_back(cyc + 1);
    if (bus.load_buffer)  load_q.push_back(cyc + 1);
    if (bus.rx_busy && !busy_p) busy_rise <= cyc;
    if (!bus.rx_busy && busy_p) busy_fall <= cyc;
    if (bus.data_ready && !dr_p) dr_rise <= cyc;
    if (bus.framing_error && !fe_p) fe_rise <= cyc;
    if (!bus.framing_error && fe_p) fe_fall <= cyc;
    if (bus.overrun_error && !ov_p) ov_rise <= cyc;
    busy_p <= bus.rx_busy;
    dr_p   <= bus.data_ready;
    fe_p   <= bus.framing_error;
    ov_p   <= bus.overrun_error;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    strobe_q.delete();
    load_q.delete();
    busy_rise = -1; busy_fall = -1; dr_rise = -1;
    fe_rise = -1; fe_fall = -1; ov_rise = -1;
  endtask

  task automatic pulse_read();
    bus.data_read = 1'b1;
    tick();
    bus.data_read = 1'b0;
    tick();
  endtask

  // Drives ncyc cycles of a frame; e is the edge on which the start bit is seen.
  task automatic send_frame(input logic [7:0] d, input logic stp, input int rd_at,
                            input int ncyc, output int e);
    e = cyc + 1;
    for (int t = 0; t < ncyc; t++) begin
      if (t < 10)      bus.serial_in = 1'b0;
      else if (t < 90) bus.serial_in = d[(t - 10) / 10];
      else             bus.serial_in = stp;
      bus.data_read = (t == rd_at);
      tick();
    end
    if (ncyc >= 100) bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
  endtask

  task automatic check_strobes(input string tag, input int e);
    check({tag, "_strobe_cnt"}, strobe_q.size(), 9);
    for (int k = 0; k < 9; k++)
      if (k < strobe_q.size())
        check({tag, "_strobe_t"}, strobe_q[k] - e, 15 + 10 * k);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_strobe"}, bus.shift_strobe, 0);
    check({tag, "_load"},   bus.load_buffer, 0);
    check({tag, "_busy"},   bus.rx_busy, 0);
    check({tag, "_dr"},     bus.data_ready, 0);
    check({tag, "_fe"},     bus.framing_error, 0);
    check({tag, "_ov"},     bus.overrun_error, 0);
  endtask

  int e, e2;

  initial begin
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
    clr();

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      bus.serial_in = 1'($urandom_range(0, 1));
      bus.data_read = 1'($urandom_range(0, 1));
      tick();
      check_idle_outputs("reset");
    end
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
    tick();
    n_rst = 1'b1;
    clr();
    repeat (50) tick();
    check("quiet_strobes", strobe_q.size(), 0);
    check("quiet_loads", load_q.size(), 0);
    check("quiet_busy_rise", busy_rise, -1);
    check_idle_outputs("quiet");

    // Valid frame 0xA5
    clr();
    send_frame(8'hA5, 1'b1, -1, 100, e);
    check_strobes("a5", e);
    check("a5_load_cnt", load_q.size(), 1);
    if (load_q.size() > 0) check("a5_load_t", load_q[0] - e, 97);
    check("a5_dr_rise", dr_rise - e, 97);
    check("a5_busy_rise", busy_rise - e, 0);
    check("a5_busy_fall", busy_fall - e, 97);
    check("a5_dr", bus.data_ready, 1);
    check("a5_fe", bus.framing_error, 0);
    check("a5_ov", bus.overrun_error, 0);
    check("a5_data", sr[7:0], 8'hA5);

    // Framing error on 0x3C, data_ready left set from 0xA5
    tick(); tick();
    clr();
    send_frame(8'h3C, 1'b0, -1, 100, e);
    tick(); tick();
    check_strobes("fe", e);
    check("fe_rise", fe_rise - e, 96);
    check("fe_busy_fall", busy_fall - e, 96);
    check("fe_load_cnt", load_q.size(), 0);
    check("fe_flag", bus.framing_error, 1);
    check("fe_dr_kept", bus.data_ready, 1);
    check("fe_dr_rise", dr_rise, -1);
    check("fe_ov", bus.overrun_error, 0);
    check("fe_data", sr[7:0], 8'h3C);

    pulse_read();
    check("read_dr", bus.data_ready, 0);

    // Next valid frame clears framing_error at its start edge
    clr();
    send_frame(8'hC3, 1'b1, -1, 100, e);
    check("fe_clear_t", fe_fall - e, 0);
    check("c3_fe", bus.framing_error, 0);
    check("c3_dr", bus.data_ready, 1);
    check("c3_ov", bus.overrun_error, 0);
    check("c3_data", sr[7:0], 8'hC3);
    pulse_read();

    // Glitch: low for 3 cycles only
    clr();
    e = cyc + 1;
    bus.serial_in = 1'b0;
    repeat (3) tick();
    bus.serial_in = 1'b1;
    repeat (20) tick();
    check("gl_busy_rise", busy_rise - e, 0);
    check("gl_busy_fall", busy_fall - e, 5);
    check("gl_strobes", strobe_q.size(), 0);
    check("gl_loads", load_q.size(), 0);
    check_idle_outputs("gl");

    // Back-to-back frames without a read
    clr();
    send_frame(8'h11, 1'b1, -1, 100, e);
    check("ov1_dr", bus.data_ready, 1);
    check("ov1_ov", bus.overrun_error, 0);
    check("ov1_data", sr[7:0], 8'h11);
    send_frame(8'h22, 1'b1, -1, 100, e2);
    check("ov2_rise", ov_rise - e2, 97);
    check("ov2_ov", bus.overrun_error, 1);
    check("ov2_dr", bus.data_ready, 1);
    check("ov2_data", sr[7:0], 8'h22);
    check("ov2_load_cnt", load_q.size(), 2);
    if (load_q.size() > 1) check("ov2_load_t", load_q[1] - e2, 97);
    pulse_read();
    check("ovr_dr", bus.data_ready, 0);
    check("ovr_ov", bus.overrun_error, 0);

    // Read coincident with the second load edge
    clr();
    send_frame(8'h11, 1'b1, -1, 100, e);
    send_frame(8'h22, 1'b1, 97, 100, e2);
    check("rd_same_dr", bus.data_ready, 1);
    check("rd_same_ov", bus.overrun_error, 0);
    check("rd_same_ov_rise", ov_rise, -1);
    pulse_read();

    // Reset mid-frame
    tick(); tick();
    clr();
    send_frame(8'hFF, 1'b1, -1, 41, e);
    check("mid_strobes_before", strobe_q.size(), 3);
    n_rst = 1'b0;
    #1;
    check_idle_outputs("mid_rst");
    strobe_q.delete();
    load_q.delete();
    repeat (3) tick();
    bus.serial_in = 1'b1;
    n_rst = 1'b1;
    repeat (100) tick();
    check("mid_strobes_after", strobe_q.size(), 0);
    check("mid_loads_after", load_q.size(), 0);
    check("mid_busy", bus.rx_busy, 0);

    clr();
    send_frame(8'h5A, 1'b1, -1, 100, e);
    check_strobes("5a", e);
    check("5a_load_cnt", load_q.size(), 1);
    if (load_q.size() > 0) check("5a_load_t", load_q[0] - e, 97);
    check("5a_dr", bus.data_ready, 1);
    check("5a_fe", bus.framing_error, 0);
    check("5a_data", sr[7:0], 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
